// File: rtl/start_ctrl_multi.sv
// start_ctrl_multi: run-start controller for the multichannel generator.
// It collects start requests from the button, the PC link and the electro-light input.
// It holds st_o high for one run. A run ends when every enabled channel has ended
// and a hold-off has elapsed, or when the optional RUN watchdog expires.
module start_ctrl_multi #(
  parameter int N_CH        = 16,
  parameter int HOLD_CYCLES = 100000000,
  parameter int HOLD_W      = 27,
  parameter int DEB_CYCLES  = 500000,
  parameter int DEB_W       = 19,
  parameter int TMO_CYCLES  = 0,
  parameter int TMO_W       = 32
) (
  input  logic            st_clk,
  input  logic            st_rst_n,
  input  logic            st_button,
  input  logic            PC_start,
  input  logic            st_ellight,
  input  logic [N_CH-1:0] ch_mask,
  input  logic [N_CH-1:0] end_flg,
  output logic            st_o,
  output logic            st_busy,
  output logic            done_pulse,
  output logic            tmo_pulse,
  output logic [15:0]     run_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  localparam logic [HOLD_W-1:0] HOLD_LAST = (HOLD_CYCLES <= 1) ? '0 : HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = (TMO_CYCLES <= 1) ? '0 : TMO_W'(TMO_CYCLES - 1);
  localparam logic [DEB_W-1:0]  DEB_MAX   = DEB_W'(DEB_CYCLES);
  localparam bit                TMO_EN    = (TMO_CYCLES != 0);

  // Reset assertion takes effect at once, and reset release is retimed to st_clk
  logic [1:0] rst_sync_reg;
  logic       rst_n_int;

  // Reset release synchroniser
  always_ff @(posedge st_clk or negedge st_rst_n) begin
    if (!st_rst_n) rst_sync_reg <= 2'b00;
    else           rst_sync_reg <= {rst_sync_reg[0], 1'b1};
  end
  assign rst_n_int = rst_sync_reg[1];

  // Bit 0 is the button, which idles high, so its synchroniser resets to 1
  logic [2:0] raw_in;
  logic [2:0] sync_val;
  assign raw_in = {st_ellight, PC_start, st_button};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_sync
      localparam logic RST_VAL = (gi == 0);
      logic s1_reg, s2_reg;
      // Two-flop synchroniser for one asynchronous input
      always_ff @(posedge st_clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
          s1_reg <= RST_VAL;
          s2_reg <= RST_VAL;
        end else begin
          s1_reg <= raw_in[gi];
          s2_reg <= s1_reg;
        end
      end
      assign sync_val[gi] = s2_reg;
    end
  endgenerate

  logic             btn_sync;
  logic [DEB_W-1:0] deb_cnt_reg;
  logic             pressed;
  logic             pressed_d_reg;
  logic [2:1]       lvl_d_reg;
  logic             start_req_reg;

  assign btn_sync = sync_val[0];
  // A press is active only while the button still reads low
  assign pressed  = (deb_cnt_reg == DEB_MAX) && !btn_sync;

  // Debounce: count low cycles, saturate at the threshold, clear on any high
  always_ff @(posedge st_clk or negedge rst_n_int) begin
    if (!rst_n_int)             deb_cnt_reg <= '0;
    else if (btn_sync)          deb_cnt_reg <= '0;
    else if (deb_cnt_reg != DEB_MAX) deb_cnt_reg <= deb_cnt_reg + DEB_W'(1);
  end

  // Rising-edge detection, merged into one registered start request
  always_ff @(posedge st_clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      pressed_d_reg <= 1'b0;
      lvl_d_reg     <= '0;
      start_req_reg <= 1'b0;
    end else begin
      pressed_d_reg <= pressed;
      lvl_d_reg     <= sync_val[2:1];
      start_req_reg <= (pressed & ~pressed_d_reg) | |(sync_val[2:1] & ~lvl_d_reg);
    end
  end

  state_t            state_reg;
  logic [N_CH-1:0]   act_mask_reg;
  logic [HOLD_W-1:0] hold_cnt_reg;
  logic [TMO_W-1:0]  wdog_reg;
  logic              all_done;

  assign all_done = &(end_flg | ~act_mask_reg);

  // Run FSM with registered outputs; all_done takes priority over the watchdog
  always_ff @(posedge st_clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state_reg    <= IDLE;
      act_mask_reg <= '0;
      hold_cnt_reg <= '0;
      wdog_reg     <= '0;
      run_cnt      <= '0;
      st_o         <= 1'b0;
      st_busy      <= 1'b0;
      done_pulse   <= 1'b0;
      tmo_pulse    <= 1'b0;
    end else begin
      done_pulse <= 1'b0;
      tmo_pulse  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start_req_reg && (ch_mask != '0)) begin
            act_mask_reg <= ch_mask;
            run_cnt      <= run_cnt + 16'd1;
            wdog_reg     <= '0;
            hold_cnt_reg <= '0;
            state_reg    <= RUN;
            st_o         <= 1'b1;
            st_busy      <= 1'b1;
          end
        end
        RUN: begin
          if (all_done) begin
            hold_cnt_reg <= '0;
            state_reg    <= HOLD;
          end else if (TMO_EN && (wdog_reg == TMO_LAST)) begin
            state_reg <= IDLE;
            st_o      <= 1'b0;
            st_busy   <= 1'b0;
            tmo_pulse <= 1'b1;
          end else begin
            wdog_reg <= wdog_reg + TMO_W'(1);
          end
        end
        HOLD: begin
          // The hold-off pauses, rather than restarts, while all_done is low
          if (all_done) begin
            if (hold_cnt_reg == HOLD_LAST) begin
              hold_cnt_reg <= '0;
              state_reg    <= IDLE;
              st_o         <= 1'b0;
              st_busy      <= 1'b0;
              done_pulse   <= 1'b1;
            end else begin
              hold_cnt_reg <= hold_cnt_reg + HOLD_W'(1);
            end
          end
        end
        default: begin
          state_reg <= IDLE;
          st_o      <= 1'b0;
          st_busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_start_ctrl_multi.sv
// Scoreboard bench for start_ctrl_multi: stimulus pushes expected events
// (run start, done, timeout) with their expected cycle and run count; a
// negedge monitor pops and compares whenever the DUT shows such an event.
module tb_start_ctrl_multi;

  logic        st_clk = 1'b0;
  logic        st_rst_n;
  logic        st_button;
  logic        PC_start;
  logic        st_ellight;
  logic [3:0]  ch_mask;
  logic [3:0]  end_flg;
  logic        st_o, st_busy, done_pulse, tmo_pulse;
  logic [15:0] run_cnt;

  start_ctrl_multi #(
    .N_CH(4), .HOLD_CYCLES(10), .HOLD_W(4), .DEB_CYCLES(4), .DEB_W(3),
    .TMO_CYCLES(50), .TMO_W(8)
  ) dut (
    .st_clk(st_clk), .st_rst_n(st_rst_n), .st_button(st_button),
    .PC_start(PC_start), .st_ellight(st_ellight), .ch_mask(ch_mask),
    .end_flg(end_flg), .st_o(st_o), .st_busy(st_busy),
    .done_pulse(done_pulse), .tmo_pulse(tmo_pulse), .run_cnt(run_cnt)
  );

  always #5 st_clk = ~st_clk;

  int cyc = 0;
  always @(posedge st_clk) cyc <= cyc + 1;

  localparam int EV_START = 0;
  localparam int EV_DONE  = 1;
  localparam int EV_TMO   = 2;

  typedef struct {
    int          kind;
    int          when;
    logic [15:0] run;
  } ev_t;

  ev_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  bit  mon_en = 1'b0;
  logic st_o_prev = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_ev(input int kind, input int when, input logic [15:0] run);
    ev_t e;
    e.kind = kind;
    e.when = when;
    e.run  = run;
    exp_q.push_back(e);
  endtask

  task automatic handle(input int kind);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL unexpected_event: got kind %0d at cycle %0d, expected none", kind, cyc);
    end else begin
      e = exp_q.pop_front();
      $display("event kind=%0d cycle=%0d run_cnt=%0d (expected kind=%0d cycle=%0d run_cnt=%0d)",
               kind, cyc, run_cnt, e.kind, e.when, e.run);
      chk("event_kind", kind, e.kind);
      chk("event_cycle", cyc, e.when);
      chk("event_run_cnt", run_cnt, e.run);
      chk("busy_eq_st_o", st_busy, st_o);
      if (kind != EV_START) chk("st_o_low_on_end", st_o, 0);
    end
  endtask

  // Monitor: watch for run start, completion and timeout events
  always @(negedge st_clk) begin
    if (mon_en) begin
      if (st_o && !st_o_prev) handle(EV_START);
      if (done_pulse)         handle(EV_DONE);
      if (tmo_pulse)          handle(EV_TMO);
    end
    st_o_prev <= st_o;
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge st_clk);
  endtask

  // Start via PC (src=0) or electro-light (src=1); returns the expected start cycle
  task automatic start_src(input int src, input logic [15:0] run, output int sc);
    sc = cyc + 4;
    if (src == 0) PC_start = 1'b1; else st_ellight = 1'b1;
    expect_ev(EV_START, sc, run);
    wait_n(2);
    PC_start   = 1'b0;
    st_ellight = 1'b0;
    wait_n(8);
  endtask

  task automatic finish_run(input logic [3:0] flags, input logic [15:0] run);
    end_flg = flags;
    expect_ev(EV_DONE, cyc + 11, run);
    wait_n(14);
    end_flg = 4'h0;
    wait_n(2);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int sc, c2;
    st_rst_n   = 1'b0;
    st_button  = 1'b1;
    PC_start   = 1'b0;
    st_ellight = 1'b0;
    ch_mask    = 4'hF;
    end_flg    = 4'h0;
    wait_n(3);
    st_rst_n = 1'b1;
    wait_n(5);
    mon_en = 1'b1;

    // Reset state
    chk("rst_st_o", st_o, 0);
    chk("rst_st_busy", st_busy, 0);
    chk("rst_done", done_pulse, 0);
    chk("rst_tmo", tmo_pulse, 0);
    chk("rst_run_cnt", run_cnt, 0);

    // 1: PC start, full mask, normal completion
    start_src(0, 16'd1, sc);
    finish_run(4'hF, 16'd1);

    // 2: short button press ignored, 6-cycle press starts, long hold starts once
    st_button = 1'b0; wait_n(3); st_button = 1'b1; wait_n(10);
    st_button = 1'b0;
    expect_ev(EV_START, cyc + 8, 16'd2);
    wait_n(6); st_button = 1'b1; wait_n(4);
    finish_run(4'hF, 16'd2);
    st_button = 1'b0;
    expect_ev(EV_START, cyc + 8, 16'd3);
    wait_n(12);
    finish_run(4'hF, 16'd3);
    wait_n(70);
    st_button = 1'b1;
    wait_n(12);

    // 3: partial mask; widening ch_mask mid-run has no effect
    ch_mask = 4'b0101;
    start_src(0, 16'd4, sc);
    ch_mask = 4'hF;
    finish_run(4'b0101, 16'd4);

    // 4: watchdog timeout 50 cycles after RUN entry
    start_src(0, 16'd5, sc);
    expect_ev(EV_TMO, sc + 50, 16'd5);
    wait_n(50);

    // 5: hold counter pauses while all_done drops; PC pulses in RUN/HOLD ignored
    start_src(0, 16'd6, sc);
    PC_start = 1'b1; wait_n(2); PC_start = 1'b0; wait_n(4);
    c2 = cyc;
    end_flg = 4'hF;
    expect_ev(EV_DONE, c2 + 18, 16'd6);
    wait_n(6);
    end_flg  = 4'h0;
    PC_start = 1'b1; wait_n(2); PC_start = 1'b0;
    wait_n(5);
    end_flg = 4'hF;
    wait_n(12);
    end_flg = 4'h0;
    wait_n(6);

    // 6: reset during HOLD clears everything immediately, no pulses
    start_src(0, 16'd7, sc);
    end_flg = 4'hF;
    wait_n(4);
    st_rst_n = 1'b0;
    #1;
    chk("midrst_st_o", st_o, 0);
    chk("midrst_st_busy", st_busy, 0);
    chk("midrst_done", done_pulse, 0);
    chk("midrst_tmo", tmo_pulse, 0);
    chk("midrst_run_cnt", run_cnt, 0);
    @(negedge st_clk);
    end_flg = 4'h0;
    wait_n(3);
    st_rst_n = 1'b1;
    wait_n(16);

    // mask 0 with PC start stays idle
    ch_mask = 4'h0;
    PC_start = 1'b1; wait_n(2); PC_start = 1'b0; wait_n(15);
    chk("mask0_st_o", st_o, 0);
    chk("mask0_run_cnt", run_cnt, 0);

    // electro-light start after reset counts from 1
    ch_mask = 4'hF;
    start_src(1, 16'd1, sc);
    finish_run(4'hF, 16'd1);

    wait_n(5);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
